// File: rtl/blackjack_pkg.sv
// Shared definitions for the BlackJack game datapath: state encodings, clock defaults
// and a constant-width helper.
package blackjack_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_CLK_HZ  = 50_000_000;
  localparam int DEFAULT_TICK_HZ = 2_000;
  localparam int TWO_SEC_TICKS   = 4000;

  // Minimum one bit, so that a divide-by-1 prescaler still has a legal counter width.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) != 0) w = i + 1;
    end
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_50M down to a one-cycle tick strobe every DIV enabled cycles.
module tick_prescaler #(
  parameter int DIV = 25_000
) (
  input  logic clk_50M,
  input  logic i_Reset_n,
  input  logic i_Clear,
  input  logic i_En,
  output logic o_Tick
);

  localparam int W = blackjack_pkg::clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (i_Clear) begin
      count <= '0;
    end else if (i_En) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign o_Tick = i_En && (count == LAST);

endmodule

// File: rtl/fsm_delay_timer.sv
// Request/done delay responder for the game FSM: counts a requested number of ticks.
//   state   | meaning
//   IDLE    | waiting for i_Start; i_Abort blocks a start
//   RUN     | counting ticks down; o_Busy high
//   DONE    | single-cycle o_Done, then back to IDLE
module fsm_delay_timer
  import blackjack_pkg::*;
#(
  parameter int CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int TICK_HZ = DEFAULT_TICK_HZ,
  parameter int WIDTH   = 12
) (
  input  logic             clk_50M,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_Load,
  input  logic             i_Abort,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Remaining,
  output logic             o_Tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  generate
    if (((CLK_HZ % TICK_HZ) != 0) || (DIV < 2)) begin : g_bad_div
      $error("fsm_delay_timer: CLK_HZ/TICK_HZ must be an exact integer >= 2");
    end
  endgenerate

  logic [1:0] state;
  logic       tick_run;
  logic       run_active;
  logic       pre_clear;

  assign run_active = (state == ST_RUN);
  // Keep the prescaler parked at zero outside RUN so every delay starts phase-aligned.
  assign pre_clear  = !run_active || i_Abort;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk_50M   (clk_50M),
    .i_Reset_n (i_Reset_n),
    .i_Clear   (pre_clear),
    .i_En      (run_active),
    .o_Tick    (tick_run)
  );

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= ST_IDLE;
      o_Remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!i_Abort && i_Start) begin
            if (i_Load != '0) begin
              state       <= ST_RUN;
              o_Remaining <= i_Load;
            end else begin
              state       <= ST_DONE;
              o_Remaining <= '0;
            end
          end
        end
        ST_RUN: begin
          if (i_Abort) begin
            state       <= ST_IDLE;
            o_Remaining <= '0;
          end else if (tick_run && (o_Remaining != '0)) begin
            if (o_Remaining == WIDTH'(1)) state <= ST_DONE;
            o_Remaining <= o_Remaining - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state       <= ST_IDLE;
          o_Remaining <= '0;
        end
      endcase
    end
  end

  assign o_Busy = run_active;
  assign o_Done = (state == ST_DONE);
  assign o_Tick = tick_run;

endmodule

// File: tb/tb_fsm_delay_timer.sv
// Directed and randomized checks of fsm_delay_timer against a closed-form timing model.
module tb_fsm_delay_timer;

  localparam int CLK_HZ  = 20;
  localparam int TICK_HZ = 2;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int WIDTH   = 12;

  logic             clk_50M = 1'b0;
  logic             i_Reset_n;
  logic             i_Start;
  logic [WIDTH-1:0] i_Load;
  logic             i_Abort;
  logic             o_Busy;
  logic             o_Done;
  logic [WIDTH-1:0] o_Remaining;
  logic             o_Tick;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  fsm_delay_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH)) dut (
    .clk_50M     (clk_50M),
    .i_Reset_n   (i_Reset_n),
    .i_Start     (i_Start),
    .i_Load      (i_Load),
    .i_Abort     (i_Abort),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Remaining (o_Remaining),
    .o_Tick      (o_Tick)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic done,
                         input int rem, input logic tick);
    chk({tag, " busy"}, {31'd0, o_Busy}, {31'd0, busy});
    chk({tag, " done"}, {31'd0, o_Done}, {31'd0, done});
    chk({tag, " rem"},  {20'd0, o_Remaining}, rem);
    chk({tag, " tick"}, {31'd0, o_Tick}, {31'd0, tick});
  endtask

  // One delay request of n ticks, optionally aborted at relative edge abort_at (0 = never).
  // Called #1 after an edge with the DUT idle; returns #1 after an edge.
  // e counts edges since the start was sampled; outputs are checked after each.
  task automatic run(input string tag, input int n, input int abort_at, input int tail);
    int  fin;
    int  last;
    bit  aborted;
    bit  live;
    fin  = n * DIV;
    last = ((abort_at != 0) ? abort_at : fin) + tail;
    i_Start = 1'b1;
    i_Load  = WIDTH'(n);
    i_Abort = 1'b0;
    @(posedge clk_50M); #1;
    for (int e = 0; e <= last; e++) begin
      aborted = (abort_at != 0) && (e >= abort_at);
      if (aborted)
        chk_all(tag, 1'b0, 1'b0, 0, 1'b0);
      else if (e < fin)
        chk_all(tag, 1'b1, 1'b0, n - e / DIV, ((e + 1) % DIV) == 0);
      else if (e == fin)
        chk_all(tag, 1'b0, 1'b1, 0, 1'b0);
      else
        chk_all(tag, 1'b0, 1'b0, 0, 1'b0);
      // Stray starts are legal only while RUN or DONE will ignore them.
      live    = !aborted && (e <= fin);
      i_Load  = WIDTH'($urandom);
      if (live) begin
        i_Start = ($urandom_range(0, 1) == 1) || (e == 11) || (e == fin);
        i_Abort = (e + 1 == abort_at) || ((e == fin) && ($urandom_range(0, 1) == 1));
      end else begin
        i_Start = 1'b0;
        i_Abort = ($urandom_range(0, 1) == 1);
      end
      @(posedge clk_50M); #1;
    end
    i_Start = 1'b0;
    i_Abort = 1'b0;
    chk_all({tag, " settle"}, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int n;
    int ab;
    i_Reset_n = 1'b0;
    i_Start   = 1'b0;
    i_Load    = '0;
    i_Abort   = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk_50M); #1;
      chk_all("reset_hold", 1'b0, 1'b0, 0, 1'b0);
      i_Start = 1'($urandom);
      i_Abort = 1'($urandom);
      i_Load  = WIDTH'($urandom);
    end
    i_Start = 1'b0;
    i_Abort = 1'b0;
    i_Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_50M); #1;
      chk_all("idle", 1'b0, 1'b0, 0, 1'b0);
    end

    run("load3", 3, 0, 3);
    run("load0", 0, 0, 3);
    run("abort15", 5, 15, 100);
    run("abort_final", 5, 50, 5);

    // Abort has priority over a start while idle.
    i_Start = 1'b1; i_Abort = 1'b1; i_Load = WIDTH'(7);
    @(posedge clk_50M); #1;
    i_Start = 1'b0; i_Abort = 1'b0;
    chk_all("abort_beats_start", 1'b0, 1'b0, 0, 1'b0);

    run("load4_restart", 4, 0, 0);
    run("back_to_back", 1, 0, 2);

    // Asynchronous reset mid-delay, no clock edge needed.
    i_Start = 1'b1; i_Load = WIDTH'(4);
    @(posedge clk_50M); #1;
    i_Start = 1'b0;
    repeat (16) @(posedge clk_50M);
    #1;
    chk_all("pre_reset", 1'b1, 1'b0, 3, 1'b0);
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk_50M); #1;
    i_Reset_n = 1'b1;
    @(posedge clk_50M); #1;
    run("after_reset", 2, 0, 2);

    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(0, 6);
      ab = ((n != 0) && ($urandom_range(0, 2) == 0)) ? $urandom_range(1, n * DIV) : 0;
      run("random", n, ab, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
